branch_predictor_btb: RTL and testbench
=======================================

// Module: branch_predictor_btb
// PURPOSE
// - Direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined MIPS core.
// - Sits in the fetch stage: looks up the fetch PC the same cycle and supplies a predicted next PC to the PC mux.
// - Trained from the execute stage when a branch or jump resolves.
// - Counts mispredicts, reported by the execute stage, for performance monitoring.
// PARAMETERS
// - ENTRIES   16  table depth; power of 2, >= 2
// - CNT_W     2   direction counter width, >= 1
// - ADDR_W    32  PC width
// - PERF_W    16  mispredict counter width
// - IDX_W = $clog2(ENTRIES); TAG_W = ADDR_W-IDX_W-2 (both derived localparams, not overridable)
// PORTS
// - CLK            in   1       clock, rising edge
// - nRST           in   1       asynchronous reset, ACTIVE-HIGH (1 = reset asserted)
// - lookup_en      in   1       fetch lookup valid (ihit-qualified)
// - lookup_pc      in   ADDR_W  fetch PC
// - pred_hit       out  1       valid entry with matching tag
// - pred_taken     out  1       prediction is taken
// - pred_target    out  ADDR_W  predicted next PC
// - upd_valid      in   1       resolved control-transfer update
// - upd_pc         in   ADDR_W  PC of the resolved instruction
// - upd_taken      in   1       actual outcome
// - upd_target     in   ADDR_W  actual target (branch or jump address)
// - upd_mispredict in   1       execute stage detected a misprediction
// - flush_all      in   1       invalidate the whole table
// - mispred_count  out  PERF_W  saturating mispredict count
// BEHAVIOUR
// - Index and tag: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] is ignored.
// - Entry contents: {valid, tag, target, cnt}.
// - Lookup: combinational, zero latency, reads registered table state.
//   - pred_hit = lookup_en & valid[idx] & tag match.
//   - pred_taken = pred_hit & cnt[CNT_W-1].
//   - pred_target = pred_taken ? target : lookup_pc+4; addition wraps modulo 2^ADDR_W.
//   - lookup_en=0: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
// - Update: takes effect at the next rising edge; first visible to lookups the following cycle.
//   - Hit at upd index: upd_taken increments cnt, saturating at 2^CNT_W-1. Otherwise cnt decrements, saturating at 0.
//   - Hit and upd_taken: target <= upd_target.
//   - Miss and upd_taken: allocate, overwriting any occupant. valid=1, tag and target written, cnt=2^(CNT_W-1) (weakly taken).
//   - Miss and not taken: no allocation, no state change.
// - Same-cycle lookup and update to the same index: lookup returns pre-update state. No bypass.
// - flush_all: clears every valid at the next edge; counters and targets are kept.
//   - flush_all has priority over a same-cycle upd_valid: the update is dropped.
// - mispred_count: increments on upd_valid & upd_mispredict, saturates at 2^PERF_W-1.
//   - Not cleared by flush_all.
// - Reset (async, nRST=1):
//   - Every valid=0, cnt=2^(CNT_W-1)-1 (weakly not taken), target=0, mispred_count=0.
//   - Result: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
//   - Reset mid-update discards the update.
// - CNT_W=1: counter degenerates to a last-outcome bit. Allocate sets cnt=1; reset value is 0.
// STRUCTURE
// - cpu_types_pkg gains:
//   - btb_entry_t struct (valid, tag, target, cnt), parameterised through localparam widths.
//   - BTB_CNT_WEAK_T and BTB_CNT_WEAK_NT constants.
// - One sub-module, sat_counter: parametrised width, inc/dec/load, saturating. It is instantiated once per entry and once for mispred_count.
// - Table is a register array; there is no SRAM macro.
// TESTING
// - Reset: assert nRST=1 mid-run, then lookup pc=0x40 -> pred_hit=0, pred_target=0x44; mispred_count=0.
// - Allocate: upd pc=0x40 taken target=0x100; next-cycle lookup 0x40 -> hit=1, taken=1, target=0x100.
// - Hysteresis (CNT_W=2): after the allocate above, one not-taken update -> cnt=1, taken=0, target=0x44. Two taken updates -> cnt=3. A third taken update -> cnt stays 3.
// - Aliasing (ENTRIES=16): allocate 0x40 and then 0x80 (same idx, different tag) -> lookup 0x40 misses, 0x80 hits. A not-taken miss on 0xC0 leaves the entry unchanged.
// - Same-cycle update and lookup of 0x40 -> lookup returns old state; new state appears the next cycle. flush_all with a simultaneous update -> all entries miss.
// - PERF_W=4: 20 mispredict updates -> mispred_count=15. flush_all -> count unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch target buffer entry layout and counter encodings.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cpu_types_pkg;

  // Default BTB geometry for the core; the BTB module takes these as parameter defaults.
  localparam int BTB_ENTRIES = 16;
  localparam int BTB_CNT_W   = 2;
  localparam int BTB_ADDR_W  = 32;
  localparam int BTB_PERF_W  = 16;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int BTB_TAG_W   = BTB_ADDR_W - BTB_IDX_W - 2;

  // Weakly-taken is the MSB alone; weakly-not-taken sits just below it.
  // With a 1-bit counter these degenerate to 1 and 0 (last-outcome bit).
  function automatic int btb_cnt_weak_t(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  function automatic int btb_cnt_weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  localparam logic [BTB_CNT_W-1:0] BTB_CNT_WEAK_T  = BTB_CNT_W'(btb_cnt_weak_t(BTB_CNT_W));
  localparam logic [BTB_CNT_W-1:0] BTB_CNT_WEAK_NT = BTB_CNT_W'(btb_cnt_weak_nt(BTB_CNT_W));

  // One table entry at the default geometry (for trace/debug consumers).
  typedef struct packed {
    logic                  valid;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_ADDR_W-1:0] target;
    logic [BTB_CNT_W-1:0]  cnt;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with parallel load; load > inc > dec.
// Latency: count changes at the rising edge after inc/dec/load.
// Backpressure: none; inc at max and dec at zero hold the value.
// Ports: clk, rst (async active-high), inc, dec, load, load_val, count.
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      if (count != MAX_VAL) count <= count + W'(1);
    end else if (dec) begin
      if (count != '0) count <= count - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters and a mispredict counter.
// Latency: lookup is combinational off registered state; updates visible one cycle later.
// Backpressure: none; every update is absorbed, flush_all wins over a same-cycle update.
// Ports: CLK, nRST (async active-high); lookup_en/lookup_pc -> pred_hit/pred_taken/pred_target;
//        upd_valid/upd_pc/upd_taken/upd_target/upd_mispredict from execute; flush_all; mispred_count.
module branch_predictor_btb
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int CNT_W   = BTB_CNT_W,
  parameter int ADDR_W  = BTB_ADDR_W,
  parameter int PERF_W  = BTB_PERF_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              flush_all,
  output logic [PERF_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(btb_cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(btb_cnt_weak_nt(CNT_W));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];

  assign pred_hit    = lookup_en && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);

  // Update side
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_go;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_go  = upd_valid && !flush_all;

  // Byte offset of the resolved PC carries no information for word-aligned MIPS code.
  logic unused_upd_lsb;
  assign unused_upd_lsb = ^upd_pc[1:0];

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (flush_all) begin
      // Only valid bits are cleared; tags and targets are dead until reallocated.
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
      end
    end
  end

  // Direction counters: train on hits, restart at weakly-taken on allocation.
  for (genvar e = 0; e < ENTRIES; e++) begin : g_cnt
    logic sel;
    assign sel = upd_go && (upd_idx == IDX_W'(e));

    sat_counter #(
      .W       (CNT_W),
      .RST_VAL (CNT_WEAK_NT)
    ) u_cnt (
      .clk      (CLK),
      .rst      (nRST),
      .inc      (sel && upd_hit && upd_taken),
      .dec      (sel && upd_hit && !upd_taken),
      .load     (sel && !upd_hit && upd_taken),
      .load_val (CNT_WEAK_T),
      .count    (cnt_q[e])
    );
  end

  // Mispredicts are a performance event of the execute stage, so they are counted
  // even in a cycle where flush_all drops the table update.
  sat_counter #(
    .W       (PERF_W),
    .RST_VAL ('0)
  ) u_mispred (
    .clk      (CLK),
    .rst      (nRST),
    .inc      (upd_valid && upd_mispredict),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .count    (mispred_count)
  );

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

  localparam int E  = 16;
  localparam int CW = 2;
  localparam int AW = 32;
  localparam int PW = 4;
  localparam int IW = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          lookup_en;
  logic [AW-1:0] lookup_pc;
  logic          pred_hit;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          upd_valid;
  logic [AW-1:0] upd_pc;
  logic          upd_taken;
  logic [AW-1:0] upd_target;
  logic          upd_mispredict;
  logic          flush_all;
  logic [PW-1:0] mispred_count;

  branch_predictor_btb #(
    .ENTRIES (E),
    .CNT_W   (CW),
    .ADDR_W  (AW),
    .PERF_W  (PW)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .lookup_en      (lookup_en),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .flush_all      (flush_all),
    .mispred_count  (mispred_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain table of branch records, indexed by word address mod E.
  bit          m_valid  [E];
  logic [31:0] m_tag    [E];
  logic [31:0] m_target [E];
  int          m_cnt    [E];
  int          m_count;

  typedef struct {
    logic        en;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        fl;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic [31:0] lpc, input logic uv,
                              input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                              input logic fl, input logic eh, input logic et,
                              input logic [31:0] etgt);
    vec_t v;
    v.en = en; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.um = 1'b0; v.fl = fl; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % E);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (2 + IW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < E; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_cnt[i]    = (1 << (CW - 1)) - 1;
    end
    m_count = 0;
  endtask

  task automatic model_update(input vec_t v);
    int  i;
    bit  hit;
    int  cmax;
    cmax = (1 << CW) - 1;
    if (v.uv && v.um && m_count < (1 << PW) - 1) m_count++;
    if (v.fl) begin
      for (int k = 0; k < E; k++) m_valid[k] = 1'b0;
    end else if (v.uv) begin
      i   = m_idx(v.upc);
      hit = m_valid[i] && (m_tag[i] == m_tagof(v.upc));
      if (hit) begin
        if (v.ut) begin
          if (m_cnt[i] < cmax) m_cnt[i]++;
          m_target[i] = v.utgt;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i]--;
        end
      end else if (v.ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = m_tagof(v.upc);
        m_target[i] = v.utgt;
        m_cnt[i]    = 1 << (CW - 1);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, check combinational outputs, clock once, advance model.
  task automatic apply(input vec_t v, input bit use_tab);
    int          i;
    bit          mh;
    bit          mt;
    logic [31:0] mtg;
    lookup_en      = v.en;
    lookup_pc      = v.lpc;
    upd_valid      = v.uv;
    upd_pc         = v.upc;
    upd_taken      = v.ut;
    upd_target     = v.utgt;
    upd_mispredict = v.um;
    flush_all      = v.fl;
    #1;
    i   = m_idx(v.lpc);
    mh  = v.en && m_valid[i] && (m_tag[i] == m_tagof(v.lpc));
    mt  = mh && (m_cnt[i] >= (1 << (CW - 1)));
    mtg = mt ? m_target[i] : v.lpc + 32'd4;
    if (use_tab) begin
      mh = v.eh; mt = v.et; mtg = v.etgt;
    end
    chk("pred_hit",    pred_hit,    mh);
    chk("pred_taken",  pred_taken,  mt);
    chk("pred_target", pred_target, mtg);
    chk("mispred_count", mispred_count, m_count);
    @(posedge CLK);
    model_update(v);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    lookup_en = 0; lookup_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
    upd_target = '0; upd_mispredict = 0; flush_all = 0;
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    nRST = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
    chk("reset_mispred_count", mispred_count, 32'd0);

    // Directed sequence: allocate, hysteresis, saturation, aliasing, same-cycle, flush.
    vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h44));
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h44));
    vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h100));
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h0,   0, 1, 1, 32'h100));
    vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 0, 32'h44));
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 1, 0, 32'h44));
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h180, 0, 1, 1, 32'h100));
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h180, 0, 1, 1, 32'h180));
    vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h0,   0, 1, 1, 32'h180));
    vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h180));
    vecs.push_back(mk(1, 32'h80, 1, 32'h80, 1, 32'h200, 0, 0, 0, 32'h84));
    vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h44));
    vecs.push_back(mk(1, 32'h80, 1, 32'hC0, 0, 32'h0,   0, 1, 1, 32'h200));
    vecs.push_back(mk(1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h200));
    vecs.push_back(mk(0, 32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h84));
    vecs.push_back(mk(1, 32'h80, 1, 32'h144, 1, 32'h300, 1, 1, 1, 32'h200));
    vecs.push_back(mk(1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h84));
    vecs.push_back(mk(1, 32'h144, 0, 32'h0, 0, 32'h0,   0, 0, 0, 32'h148));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0));
    foreach (vecs[k]) apply(vecs[k], 1'b1);

    // Mispredict counter saturation and persistence across flush.
    for (int k = 0; k < 20; k++) begin
      v = mk(1, 32'h300, 1, 32'h300, 0, 32'h0, 0, 0, 0, 32'h0);
      v.um = 1'b1;
      apply(v, 1'b0);
    end
    chk("mispred_sat", mispred_count, 32'd15);
    apply(mk(0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h4), 1'b0);
    chk("mispred_after_flush", mispred_count, 32'd15);

    // Reset asserted mid-cycle while an update is pending.
    apply(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h0), 1'b0);
    lookup_en = 1; lookup_pc = 32'h40; upd_valid = 1; upd_pc = 32'h40;
    upd_taken = 1; upd_target = 32'h500; upd_mispredict = 1; flush_all = 0;
    #2 nRST = 1'b1;
    #1;
    model_reset();
    chk("rst_pred_hit",    pred_hit,      32'd0);
    chk("rst_pred_target", pred_target,   32'h44);
    chk("rst_mispred",     mispred_count, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b0;
    apply(mk(1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h44), 1'b1);

    // Random traffic on a small PC pool so aliasing and retraining happen often.
    for (int k = 0; k < 2000; k++) begin
      logic [31:0] lpc;
      logic [31:0] upc;
      lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) lpc = lpc | 32'hFFFF_0000;
      if ($urandom_range(0, 2) == 0) lpc = upc;
      v = mk($urandom_range(0, 9) != 0, lpc, $urandom_range(0, 2) != 0, upc,
             $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 39) == 0, 0, 0, 32'h0);
      v.um = ($urandom_range(0, 3) == 0);
      apply(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
